// File: rtl/dragon_mover.sv
// dragon_mover: grid-walking dragon head that chases a target one cell per
// MOVE_PERIOD triggers, with a stun state entered on a hit.
// Optional macro DRAGON_DIAGONAL_EN enables diagonal steps when both axes differ.
module dragon_mover #(
  parameter int unsigned MOVE_PERIOD   = 4,
  parameter int unsigned STUN_TRIGGERS = 8,
  parameter logic [7:0]  RESET_POS     = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       enable,
  input  logic [7:0] target_pos,
  input  logic [7:0] player_pos,
  input  logic [7:0] sheep_pos,
  input  logic       dragon_hurt,
  output logic [7:0] dragon_pos,
  output logic [6:0] dragon_state,
  output logic       target_reached_player,
  output logic       target_reached_sheep
);

  typedef enum logic {MOVE, STUN} state_t;

  localparam logic [3:0] PERIOD_LAST = 4'(MOVE_PERIOD - 1);
  localparam logic [7:0] STUN_LOAD   = 8'(STUN_TRIGGERS);
  localparam logic [3:0] Y_MAX       = 4'd11;

  state_t      state, state_nxt;
  logic [3:0]  period_cnt, period_nxt;
  logic [7:0]  stun_cnt, stun_nxt;
  logic [7:0]  pos, pos_nxt;
  logic [1:0]  dir, dir_nxt;
  logic        moving, moving_nxt;
  logic [2:0]  step_cnt, step_nxt;

  logic [3:0]        x, y, tx, ty;
  logic signed [4:0] dx, dy;
  logic [4:0]        adx, ady;
  logic [3:0]        step_x, step_y;
  logic [1:0]        step_dir;
  logic              step_moves;

  // Candidate step toward the (y-clamped) target from the current cell
  always_comb begin
    x          = pos[7:4];
    y          = pos[3:0];
    tx         = target_pos[7:4];
    ty         = (target_pos[3:0] > Y_MAX) ? Y_MAX : target_pos[3:0];
    dx         = signed'({1'b0, tx}) - signed'({1'b0, x});
    dy         = signed'({1'b0, ty}) - signed'({1'b0, y});
    adx        = dx[4] ? 5'(-dx) : 5'(dx);
    ady        = dy[4] ? 5'(-dy) : 5'(dy);
    step_x     = x;
    step_y     = y;
    step_dir   = dir;
    step_moves = 1'b0;
`ifdef DRAGON_DIAGONAL_EN
    if (dx != '0 && dy != '0) begin
      step_x     = dx[4] ? x - 4'd1 : x + 4'd1;
      step_y     = dy[4] ? y - 4'd1 : y + 4'd1;
      step_dir   = dx[4] ? 2'b11 : 2'b01;
      step_moves = 1'b1;
    end else
`endif
    if (dx != '0 && adx >= ady) begin
      step_x     = dx[4] ? x - 4'd1 : x + 4'd1;
      step_dir   = dx[4] ? 2'b11 : 2'b01;
      step_moves = 1'b1;
    end else if (dy != '0) begin
      step_y     = dy[4] ? y - 4'd1 : y + 4'd1;
      step_dir   = dy[4] ? 2'b00 : 2'b10;
      step_moves = 1'b1;
    end
  end

  // Next-state and counter/position update logic
  always_comb begin
    state_nxt  = state;
    period_nxt = period_cnt;
    stun_nxt   = stun_cnt;
    pos_nxt    = pos;
    dir_nxt    = dir;
    moving_nxt = 1'b0;
    step_nxt   = step_cnt;
    case (state)
      MOVE: begin
        // a hit wins over a coincident step
        if (dragon_hurt) begin
          state_nxt  = STUN;
          stun_nxt   = STUN_LOAD;
          step_nxt   = '0;
          period_nxt = '0;
        end else if (enable && trigger) begin
          if (period_cnt >= PERIOD_LAST) begin
            period_nxt = '0;
            if (step_moves) begin
              pos_nxt    = {step_x, step_y};
              dir_nxt    = step_dir;
              moving_nxt = 1'b1;
              if (step_cnt != 3'd7) step_nxt = step_cnt + 3'd1;
            end
          end else begin
            period_nxt = period_cnt + 4'd1;
          end
        end
      end
      STUN: begin
        if (enable && trigger) begin
          stun_nxt = stun_cnt - 8'd1;
          if (stun_cnt <= 8'd1) begin
            state_nxt  = MOVE;
            stun_nxt   = '0;
            period_nxt = '0;
          end
        end
      end
    endcase
  end

  // State, counters, position and registered reached flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= MOVE;
      period_cnt            <= '0;
      stun_cnt              <= '0;
      pos                   <= RESET_POS;
      dir                   <= '0;
      moving                <= 1'b0;
      step_cnt              <= '0;
      target_reached_player <= 1'b0;
      target_reached_sheep  <= 1'b0;
    end else begin
      state                 <= state_nxt;
      period_cnt            <= period_nxt;
      stun_cnt              <= stun_nxt;
      pos                   <= pos_nxt;
      dir                   <= dir_nxt;
      moving                <= moving_nxt;
      step_cnt              <= step_nxt;
      target_reached_player <= (pos == player_pos);
      target_reached_sheep  <= (pos == sheep_pos);
    end
  end

  assign dragon_pos   = pos;
  assign dragon_state = {dir, (state == STUN), moving, step_cnt};

endmodule

// File: tb/tb_dragon_mover.sv
// Directed bench for dragon_mover: a slow instance (MOVE_PERIOD=4, start 00)
// and a fast instance (MOVE_PERIOD=1, start 55) share the same stimulus.
module tb_dragon_mover;

  logic       clk = 1'b0;
  logic       reset, trigger, enable, dragon_hurt;
  logic [7:0] target_pos, player_pos, sheep_pos;
  logic [7:0] s_pos, f_pos;
  logic [6:0] s_st, f_st;
  logic       s_rp, s_rs, f_rp, f_rs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dragon_mover #(.MOVE_PERIOD(4), .STUN_TRIGGERS(8), .RESET_POS(8'h00)) u_slow (
    .clk(clk), .reset(reset), .trigger(trigger), .enable(enable),
    .target_pos(target_pos), .player_pos(player_pos), .sheep_pos(sheep_pos),
    .dragon_hurt(dragon_hurt), .dragon_pos(s_pos), .dragon_state(s_st),
    .target_reached_player(s_rp), .target_reached_sheep(s_rs));

  dragon_mover #(.MOVE_PERIOD(1), .STUN_TRIGGERS(8), .RESET_POS(8'h55)) u_fast (
    .clk(clk), .reset(reset), .trigger(trigger), .enable(enable),
    .target_pos(target_pos), .player_pos(player_pos), .sheep_pos(sheep_pos),
    .dragon_hurt(dragon_hurt), .dragon_pos(f_pos), .dragon_state(f_st),
    .target_reached_player(f_rp), .target_reached_sheep(f_rs));

  typedef struct {
    logic       rst, trig, en, hurt;
    logic [7:0] tgt;
    logic       sel;   // 0 = slow instance, 1 = fast instance
    logic [7:0] pos;
    logic [6:0] st;
    logic [1:0] flg;   // {reached_player, reached_sheep}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic trig, input logic en, input logic hurt,
                     input logic [7:0] tgt, input logic sel, input logic [7:0] pos,
                     input logic [6:0] st, input logic [1:0] flg);
    vec_t v;
    v.rst = rst; v.trig = trig; v.en = en; v.hurt = hurt; v.tgt = tgt;
    v.sel = sel; v.pos = pos; v.st = st; v.flg = flg;
    vecs.push_back(v);
  endtask

  task automatic addn(input int n, input logic trig, input logic en, input logic [7:0] tgt,
                      input logic [7:0] pos, input logic [6:0] st);
    for (int k = 0; k < n; k++) add(1'b0, trig, en, 1'b0, tgt, 1'b0, pos, st, 2'b00);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // one clock cycle with the given inputs; outputs sampled 1ns after the edge
  task automatic cyc(input logic rst, input logic trig, input logic en, input logic hurt,
                     input logic [7:0] tgt);
    @(negedge clk);
    reset = rst; trigger = trig; enable = en; dragon_hurt = hurt; target_pos = tgt;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] path [14];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; trigger = 1'b0; enable = 1'b1; dragon_hurt = 1'b0;
    target_pos = 8'h30; player_pos = 8'h33; sheep_pos = 8'h33;

    // slow: reset, partial period, reset again (counter must restart)
    add(1, 0, 1, 0, 8'h30, 0, 8'h00, 7'b0000000, 2'b00);
    addn(2, 1, 1, 8'h30, 8'h00, 7'b0000000);
    add(1, 0, 1, 0, 8'h30, 0, 8'h00, 7'b0000000, 2'b00);
    // slow: chase 30, step every 4th trigger
    addn(3, 1, 1, 8'h30, 8'h00, 7'b0000000);
    addn(1, 1, 1, 8'h30, 8'h10, 7'b0101001);
    addn(1, 0, 1, 8'h30, 8'h10, 7'b0100001);
    addn(3, 1, 1, 8'h30, 8'h10, 7'b0100001);
    addn(1, 1, 1, 8'h30, 8'h20, 7'b0101010);
    addn(3, 1, 1, 8'h30, 8'h20, 7'b0100010);
    addn(1, 1, 1, 8'h30, 8'h30, 7'b0101011);
    addn(4, 1, 1, 8'h30, 8'h30, 7'b0100011);
    // slow: hit on the step trigger, 8-trigger stun, re-hit ignored, enable=0 holds
    addn(3, 1, 1, 8'h70, 8'h30, 7'b0100011);
    add(0, 1, 1, 1, 8'h70, 0, 8'h30, 7'b0110000, 2'b00);
    addn(3, 1, 1, 8'h70, 8'h30, 7'b0110000);
    add(0, 1, 1, 1, 8'h70, 0, 8'h30, 7'b0110000, 2'b00);
    addn(2, 1, 0, 8'h70, 8'h30, 7'b0110000);
    addn(3, 1, 1, 8'h70, 8'h30, 7'b0110000);
    addn(1, 1, 1, 8'h70, 8'h30, 7'b0100000);
    addn(3, 1, 1, 8'h70, 8'h30, 7'b0100000);
    addn(1, 1, 1, 8'h70, 8'h40, 7'b0101001);
    // fast: 55 -> 52 moving up, then hold
    add(1, 0, 1, 0, 8'h52, 1, 8'h55, 7'b0000000, 2'b00);
    add(0, 1, 1, 0, 8'h52, 1, 8'h54, 7'b0001001, 2'b00);
    add(0, 1, 1, 0, 8'h52, 1, 8'h53, 7'b0001010, 2'b00);
    add(0, 1, 1, 0, 8'h52, 1, 8'h52, 7'b0001011, 2'b00);
    add(0, 1, 1, 0, 8'h52, 1, 8'h52, 7'b0000011, 2'b00);
    add(0, 0, 1, 0, 8'h52, 1, 8'h52, 7'b0000011, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].trig, vecs[i].en, vecs[i].hurt, vecs[i].tgt);
      check($sformatf("vec%0d_pos", i), 32'(vecs[i].sel ? f_pos : s_pos), 32'(vecs[i].pos));
      check($sformatf("vec%0d_state", i), 32'(vecs[i].sel ? f_st : s_st), 32'(vecs[i].st));
      check($sformatf("vec%0d_flags", i),
            32'(vecs[i].sel ? {f_rp, f_rs} : {s_rp, s_rs}), 32'(vecs[i].flg));
    end

    // fast: 55 -> F9 walk (step rule, step_count saturation), then y clamp
    path = '{8'h65, 8'h75, 8'h85, 8'h95, 8'hA5, 8'hB5, 8'hC5,
             8'hC6, 8'hD6, 8'hD7, 8'hE7, 8'hE8, 8'hF8, 8'hF9};
    cyc(1, 0, 1, 0, 8'hF9);
    check("walk_reset_pos", 32'(f_pos), 32'h55);
    for (int i = 0; i < 14; i++) begin
      cyc(0, 1, 1, 0, 8'hF9);
      check($sformatf("walk%0d_pos", i), 32'(f_pos), 32'(path[i]));
    end
    check("walk_state", 32'(f_st), 32'(7'b1001111));
    cyc(0, 1, 1, 0, 8'hFF);
    check("clamp1_pos", 32'(f_pos), 32'hFA);
    cyc(0, 1, 1, 0, 8'hFF);
    check("clamp2_pos", 32'(f_pos), 32'hFB);
    check("clamp2_state", 32'(f_st), 32'(7'b1001111));
    cyc(0, 1, 1, 0, 8'hFF);
    check("clamp3_pos", 32'(f_pos), 32'hFB);
    check("clamp3_state", 32'(f_st), 32'(7'b1000111));

    // fast: reach 33, flags one cycle later, enable=0 freezes movement
    cyc(1, 0, 1, 0, 8'h33);
    cyc(0, 1, 1, 0, 8'h33); check("arr1_pos", 32'(f_pos), 32'h45);
    cyc(0, 1, 1, 0, 8'h33); check("arr2_pos", 32'(f_pos), 32'h44);
    cyc(0, 1, 1, 0, 8'h33); check("arr3_pos", 32'(f_pos), 32'h34);
    cyc(0, 1, 1, 0, 8'h33); check("arr4_pos", 32'(f_pos), 32'h33);
    check("arr4_flags", 32'({f_rp, f_rs}), 32'h0);
    cyc(0, 0, 1, 0, 8'h33);
    check("arr5_flags", 32'({f_rp, f_rs}), 32'h3);
    check("arr5_state", 32'(f_st), 32'(7'b0000100));
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0, 8'h00);
      check($sformatf("frozen%0d_pos", i), 32'(f_pos), 32'h33);
    end
    check("frozen_state", 32'(f_st), 32'(7'b0000100));
    check("frozen_flags", 32'({f_rp, f_rs}), 32'h3);
    cyc(0, 1, 1, 0, 8'h00);
    check("leave_pos", 32'(f_pos), 32'h23);
    check("leave_state", 32'(f_st), 32'(7'b1101101));
    check("leave_flags", 32'({f_rp, f_rs}), 32'h3);
    cyc(0, 0, 1, 0, 8'h00);
    check("left_flags", 32'({f_rp, f_rs}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
